uart_rx_frame: RTL and testbench

Serial receiver for the link driven by the pipeline transmitter. It takes the transmitter's `dout` line and recovers each frame using 16x oversampling, with the same runtime frame options the transmitter uses (`dnum`, `snum`, `par`). Each received byte is presented with one-cycle valid and error flags to the downstream ADC/timestamp consumer. The block runs on the system clock and advances only on `os_tick` strobes from the frequency divider.

---
 rtl/uart_rx_frame.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART frame receiver (7/8 data, opt parity, 1/2 stop).
// Ports: clk, rst (async active-low), os_tick (16x baud enable), din (serial line),
//   dnum/snum/par (frame options, latched at start), rx_data/rx_valid/parity_err/
//   frame_err (result, updated together on completion), busy (frame in progress).
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at tc=6/7/8.
module uart_rx_frame #(
  parameter int OS_RATE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       os_tick,
  input  logic       din,
  input  logic       dnum,
  input  logic       snum,
  input  logic [1:0] par,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_e;

  localparam logic [3:0] LAST = 4'(OS_RATE - 1);

  state_e      state_q;
  logic [3:0]  tc_q;
  logic [3:0]  tc_d;
  logic        sync_q;
  logic        ds_q;
  logic        dsp_q;
  logic        dnum_q;
  logic        snum_q;
  logic [1:0]  par_q;
  logic [2:0]  bit_q;
  logic [7:0]  shf_q;
  logic        perr_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        perr_out_q;
  logic        ferr_out_q;
  logic        busy_q;

  logic        smp;
  logic        at_smp;
  logic        last;
  logic        fall;
  logic        has_par;
  logic        par_bad;
  logic [2:0]  top_bit;
  logic        done;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SAMP = 4'd8;
  logic m6_q;
  logic m7_q;
  // Bit value is the majority of tc=6, tc=7 and the live tc=8 sample.
  assign smp = (m6_q & m7_q) | (m6_q & ds_q) | (m7_q & ds_q);
`else
  localparam logic [3:0] SAMP = 4'd7;
  assign smp = ds_q;
`endif

  assign tc_d    = tc_q + 4'd1;
  assign at_smp  = (tc_q == SAMP);
  assign last    = (tc_q == LAST);
  assign fall    = dsp_q & ~ds_q;
  assign has_par = ^par_q;
  assign top_bit = {2'b11, dnum_q};
  // par_q[0]=1 (odd) flips the sense: odd wants data^p = 1.
  assign par_bad = (^shf_q) ^ smp ^ par_q[0];

  // Frame ends at the stop-bit midpoint; a low first stop bit ends it early.
  assign done = os_tick && at_smp &&
                (((state_q == STOP1) && (!snum_q || !smp)) ||
                 (state_q == STOP2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tc_q       <= '0;
      sync_q     <= 1'b1;
      ds_q       <= 1'b1;
      dsp_q      <= 1'b1;
      dnum_q     <= 1'b0;
      snum_q     <= 1'b0;
      par_q      <= 2'b00;
      bit_q      <= '0;
      shf_q      <= '0;
      perr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      m6_q       <= 1'b1;
      m7_q       <= 1'b1;
`endif
    end else begin
      sync_q     <= din;
      ds_q       <= sync_q;
      rx_valid_q <= 1'b0;
      if (os_tick) begin
        dsp_q <= ds_q;
        tc_q  <= tc_d;
`ifdef UART_RX_MAJORITY_EN
        if (tc_q == 4'd6) m6_q <= ds_q;
        if (tc_q == 4'd7) m7_q <= ds_q;
`endif
        unique case (state_q)
          IDLE: begin
            tc_q <= '0;
            // Needs a real high-to-low edge; a held-low line never restarts.
            if (fall) begin
              state_q <= START;
              busy_q  <= 1'b1;
              dnum_q  <= dnum;
              snum_q  <= snum;
              par_q   <= par;
              shf_q   <= '0;
              bit_q   <= '0;
              perr_q  <= 1'b0;
            end
          end
          START: begin
            if (at_smp && smp) begin
              state_q <= IDLE;
              tc_q    <= '0;
              busy_q  <= 1'b0;
            end else if (last) begin
              state_q <= DATA;
            end
          end
          DATA: begin
            if (at_smp) shf_q[bit_q] <= smp;
            if (last) begin
              if (bit_q == top_bit) begin
                bit_q   <= '0;
                state_q <= has_par ? PARITY : STOP1;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end
          end
          PARITY: begin
            if (at_smp) perr_q <= par_bad;
            if (last) state_q <= STOP1;
          end
          STOP1: begin
            if (last) state_q <= STOP2;
          end
          STOP2: begin
          end
          default: state_q <= IDLE;
        endcase
        if (done) begin
          state_q    <= IDLE;
          tc_q       <= '0;
          busy_q     <= 1'b0;
          rx_valid_q <= 1'b1;
          rx_data_q  <= shf_q;
          perr_out_q <= perr_q;
          ferr_out_q <= ~smp;
        end
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame.
// os_tick every 4 clk; line bits are held 16 ticks each.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       os_tick = 1'b0;
  logic       din = 1'b1;
  logic       dnum = 1'b1;
  logic       snum = 1'b0;
  logic [1:0] par = 2'b00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

`ifdef UART_RX_MAJORITY_EN
  localparam int MJ = 1;
`else
  localparam int MJ = 0;
`endif

  uart_rx_frame dut (
    .clk       (clk),
    .rst       (rst),
    .os_tick   (os_tick),
    .din       (din),
    .dnum      (dnum),
    .snum      (snum),
    .par       (par),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tdiv = 0;
  always @(negedge clk) begin
    tdiv    = (tdiv == 3) ? 0 : tdiv + 1;
    os_tick = (tdiv == 0);
  end

  int tick_n = 0;
  always @(posedge clk) if (os_tick) tick_n <= tick_n + 1;

  int         vcount = 0;
  int         vlong = 0;
  int         vtick[16];
  logic [7:0] vdata[16];
  logic       vprev = 1'b0;
  always @(posedge clk) begin
    if (rx_valid) begin
      vtick[vcount % 16] <= tick_n;
      vdata[vcount % 16] <= rx_data;
      vcount <= vcount + 1;
      if (vprev) vlong <= vlong + 1;
    end
    vprev <= rx_valid;
  end

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!os_tick);
    end
    #1;
  endtask

  task automatic send(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      din = b[i];
      wait_ticks(16);
    end
  endtask

  int v0;
  int t0;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5
    dnum = 1'b1; snum = 1'b0; par = 2'b00;
    v0 = vcount; t0 = tick_n;
    send({6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
    din = 1'b1;
    wait_ticks(4);
    chk("a5_cnt", vcount, v0 + 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_perr", parity_err, 1'b0);
    chk("a5_ferr", frame_err, 1'b0);
    chk("a5_busy", busy, 1'b0);
    chk("a5_lat", vtick[v0 % 16] - t0, 153 + MJ);

    // 7E1 0x35, ones=4 so the even parity bit is 0
    dnum = 1'b0; par = 2'b10;
    v0 = vcount; t0 = tick_n;
    send({6'h3f, 1'b1, 1'b0, 7'h35, 1'b0}, 10);
    wait_ticks(4);
    chk("e35_cnt", vcount, v0 + 1);
    chk("e35_data", rx_data, 8'h35);
    chk("e35_perr", parity_err, 1'b0);
    chk("e35_lat", vtick[v0 % 16] - t0, 153 + MJ);

    // same with the parity bit flipped
    v0 = vcount;
    send({6'h3f, 1'b1, 1'b1, 7'h35, 1'b0}, 10);
    wait_ticks(4);
    chk("e35b_cnt", vcount, v0 + 1);
    chk("e35b_data", rx_data, 8'h35);
    chk("e35b_perr", parity_err, 1'b1);
    chk("e35b_ferr", frame_err, 1'b0);

    // 8O2 0x00, odd parity bit 1, second stop low
    dnum = 1'b1; snum = 1'b1; par = 2'b01;
    v0 = vcount; t0 = tick_n;
    send({4'hf, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 12);
    chk("o2_cnt", vcount, v0 + 1);
    chk("o2_data", rx_data, 8'h00);
    chk("o2_ferr", frame_err, 1'b1);
    chk("o2_perr", parity_err, 1'b0);
    chk("o2_lat", vtick[v0 % 16] - t0, 185 + MJ);
    din = 1'b0;
    wait_ticks(40);
    chk("low_busy", busy, 1'b0);
    din = 1'b1;
    wait_ticks(20);
    chk("low_cnt", vcount, v0 + 1);
    chk("low_ferr", frame_err, 1'b1);

    // glitch: 4 ticks low
    snum = 1'b0; par = 2'b00;
    v0 = vcount;
    din = 1'b0;
    wait_ticks(4);
    chk("gl_busy1", busy, 1'b1);
    din = 1'b1;
    wait_ticks(12);
    chk("gl_busy0", busy, 1'b0);
    chk("gl_cnt", vcount, v0);
    chk("gl_ferr", frame_err, 1'b1);

    // reset after start + 3 data bits of 0x5A
    v0 = vcount;
    send(16'b0100, 4);
    wait_ticks(4);
    chk("mr_busy1", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_ferr", frame_err, 1'b0);
    chk("mr_perr", parity_err, 1'b0);
    chk("mr_data", rx_data, 8'h00);
    chk("mr_valid", rx_valid, 1'b0);
    din = 1'b1;
    #20;
    rst = 1'b1;
    wait_ticks(20);
    chk("mr_cnt", vcount, v0);
    send({6'h3f, 1'b1, 8'h5A, 1'b0}, 10);
    wait_ticks(4);
    chk("5a_cnt", vcount, v0 + 1);
    chk("5a_data", rx_data, 8'h5A);
    chk("5a_ferr", frame_err, 1'b0);

    // back-to-back 0x11 0x22 0x33
    v0 = vcount;
    send({6'h3f, 1'b1, 8'h11, 1'b0}, 10);
    send({6'h3f, 1'b1, 8'h22, 1'b0}, 10);
    send({6'h3f, 1'b1, 8'h33, 1'b0}, 10);
    wait_ticks(4);
    chk("bb_cnt", vcount, v0 + 3);
    chk("bb_d0", vdata[v0 % 16], 8'h11);
    chk("bb_d1", vdata[(v0 + 1) % 16], 8'h22);
    chk("bb_d2", vdata[(v0 + 2) % 16], 8'h33);
    chk("bb_gap1", vtick[(v0 + 1) % 16] - vtick[v0 % 16], 160);
    chk("bb_gap2", vtick[(v0 + 2) % 16] - vtick[(v0 + 1) % 16], 160);
    chk("bb_busy", busy, 1'b0);
    chk("valid_1clk", vlong, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
